// File: rtl/sram_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
// The data memory window starts at DMEM_BASE; the SRAM is 256K x 16.
package sram_pkg;

    localparam int          SRAM_ADDR_W = 18;
    localparam int          SRAM_DATA_W = 16;
    localparam logic [31:0] DMEM_BASE   = 32'd1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } sram_state_t;

endpackage

// File: rtl/sram_mem_controller.sv
// Multi-cycle MEM-stage controller: one 32-bit load/store becomes two halfword
// SRAM accesses while ready stalls the pipeline.
//
// state | meaning
// IDLE  | no word in flight; accepts rd_en/wr_en, ready drops in the request cycle
// LOW   | halfword hw accessed for ACCESS_CYCLES cycles (bits 15:0)
// HIGH  | halfword hw+1 accessed for ACCESS_CYCLES cycles (bits 31:16)
// DONE  | strobes idle, ready high, pipeline advances at this edge
module sram_mem_controller
    import sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = DMEM_BASE,
    parameter int          ACCESS_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n,
    output logic                   sram_oe_n,
    output logic                   sram_ce_n,
    output logic                   sram_ub_n,
    output logic                   sram_lb_n
);

    localparam logic [3:0] CNT_LAST = 4'(ACCESS_CYCLES - 1);

    sram_state_t            state, state_nxt;
    logic [3:0]             cnt, cnt_nxt;
    logic                   op_wr;
    logic [16:0]            word_q;
    logic [31:0]            wdata_q;
    logic                   req;
    logic                   last;
    logic                   accept;
    logic [SRAM_ADDR_W-1:0] hw_lo, hw_hi;

    assign req    = rd_en | wr_en;
    assign last   = (cnt == CNT_LAST);
    assign accept = (state == IDLE) && req;

    // Only word-aligned halfword pairs are addressed; the base is always even.
    assign hw_lo = {word_q, 1'b0};
    assign hw_hi = {word_q, 1'b1};

    assign sram_ce_n = 1'b0;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = LOW;
                    cnt_nxt   = 4'd0;
                end
            end
            LOW: begin
                if (last) begin
                    state_nxt = HIGH;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            HIGH: begin
                if (last) begin
                    state_nxt = DONE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_comb begin
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        sram_oe_n   = 1'b1;
        ready       = 1'b0;
        unique case (state)
            IDLE: ready = !req;
            LOW: begin
                sram_addr = hw_lo;
                if (op_wr) begin
                    sram_dq_out = wdata_q[15:0];
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                end else begin
                    sram_oe_n = 1'b0;
                end
            end
            HIGH: begin
                sram_addr = hw_hi;
                if (op_wr) begin
                    sram_dq_out = wdata_q[31:16];
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                end else begin
                    sram_oe_n = 1'b0;
                end
            end
            DONE: ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            op_wr     <= 1'b0;
            word_q    <= '0;
            wdata_q   <= '0;
            read_data <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                op_wr   <= wr_en;
                word_q  <= 17'((address - BASE_ADDR) >> 2);
                wdata_q <= write_data;
            end
            // Read data is sampled on the final cycle of each halfword window.
            if (!op_wr && last && state == LOW) read_data[15:0] <= sram_dq_in;
            if (!op_wr && last && state == HIGH) read_data[31:16] <= sram_dq_in;
        end
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Randomized scoreboard bench for sram_mem_controller with a behavioural SRAM
// and a word-level reference memory.
module tb_sram_mem_controller;

    localparam int A_MAIN = 2;
    localparam logic [15:0] AUX_DQ = 16'h5AA5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_en = 1'b0, wr_en = 1'b0;
    logic [31:0] address = '0, write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in = '0;
    logic        sram_dq_oe, sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

    always #5 clk = ~clk;

    sram_mem_controller #(.BASE_ADDR(32'd1024), .ACCESS_CYCLES(A_MAIN)) u_dut (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
        .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
        .sram_ce_n(sram_ce_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    // Two extra instances exercise the ACCESS_CYCLES extremes.
    logic        aux_rd = 1'b0, aux_wr = 1'b0;
    logic [31:0] aux_addr = 32'd1024, aux_wd = '0;
    logic [31:0] a1_rdata, a15_rdata;
    logic        a1_ready, a15_ready;
    logic [17:0] a1_addr, a15_addr;
    logic [15:0] a1_dq_out, a15_dq_out;
    logic        a1_dq_oe, a1_we_n, a1_oe_n, a1_ce_n, a1_ub_n, a1_lb_n;
    logic        a15_dq_oe, a15_we_n, a15_oe_n, a15_ce_n, a15_ub_n, a15_lb_n;

    sram_mem_controller #(.BASE_ADDR(32'd1024), .ACCESS_CYCLES(1)) u_a1 (
        .clk(clk), .rst_n(rst_n), .rd_en(aux_rd), .wr_en(aux_wr), .address(aux_addr),
        .write_data(aux_wd), .read_data(a1_rdata), .ready(a1_ready),
        .sram_addr(a1_addr), .sram_dq_out(a1_dq_out), .sram_dq_in(AUX_DQ),
        .sram_dq_oe(a1_dq_oe), .sram_we_n(a1_we_n), .sram_oe_n(a1_oe_n),
        .sram_ce_n(a1_ce_n), .sram_ub_n(a1_ub_n), .sram_lb_n(a1_lb_n)
    );

    sram_mem_controller #(.BASE_ADDR(32'd1024), .ACCESS_CYCLES(15)) u_a15 (
        .clk(clk), .rst_n(rst_n), .rd_en(aux_rd), .wr_en(aux_wr), .address(aux_addr),
        .write_data(aux_wd), .read_data(a15_rdata), .ready(a15_ready),
        .sram_addr(a15_addr), .sram_dq_out(a15_dq_out), .sram_dq_in(AUX_DQ),
        .sram_dq_oe(a15_dq_oe), .sram_we_n(a15_we_n), .sram_oe_n(a15_oe_n),
        .sram_ce_n(a15_ce_n), .sram_ub_n(a15_ub_n), .sram_lb_n(a15_lb_n)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Initial SRAM contents are a fixed pattern so unwritten reads are predictable.
    function automatic logic [15:0] init_hw(input int a);
        return 16'((a * 40503) + 4951);
    endfunction

    // Behavioural SRAM: write while we_n is low, drive read data while oe_n is low.
    logic [15:0] sram_mem [int];
    always @(negedge clk) begin
        if (!sram_we_n && sram_dq_oe) sram_mem[int'(sram_addr)] = sram_dq_out;
        if (!sram_oe_n)
            sram_dq_in <= sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)]
                                                           : init_hw(int'(sram_addr));
        else
            sram_dq_in <= '0;
    end

    // Word-level reference model.
    logic [31:0] ref_mem [int];
    logic [31:0] last_read = '0;

    function automatic logic [31:0] ref_word(input int idx);
        if (ref_mem.exists(idx)) return ref_mem[idx];
        return {init_hw(2 * idx + 1), init_hw(2 * idx)};
    endfunction

    typedef struct {
        logic        is_rd;
        logic [31:0] exp_rd;
        logic [31:0] wd;
        logic [17:0] hw;
    } exp_t;

    exp_t sb_q[$];
    int   issued = 0;
    int   done_cnt = 0;

    // Monitor: accumulates one transaction while ready is low, scores it at DONE.
    int          stall = 0, lo_cnt = 0, hi_cnt = 0;
    logic [17:0] lo_addr = '0, hi_addr = '0;
    logic [15:0] lo_data = '0, hi_data = '0;
    logic        saw_wr = 1'b0, saw_rd = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stall = 0; lo_cnt = 0; hi_cnt = 0; saw_wr = 1'b0; saw_rd = 1'b0;
        end else if (!ready) begin
            stall++;
            if (!sram_we_n || !sram_oe_n) begin
                if (!sram_we_n) saw_wr = 1'b1;
                if (!sram_oe_n) saw_rd = 1'b1;
                if (lo_cnt == 0 || (sram_addr == lo_addr && hi_cnt == 0)) begin
                    lo_addr = sram_addr; lo_data = sram_dq_out; lo_cnt++;
                end else begin
                    hi_addr = sram_addr; hi_data = sram_dq_out; hi_cnt++;
                end
            end
        end else if (stall > 0) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_done", 64'(stall), 64'(0));
            end else begin
                e = sb_q.pop_front();
                check("done_read_data", 64'(read_data), 64'(e.exp_rd));
                check("ready_low_cycles", 64'(stall), 64'(2 * A_MAIN + 1));
                check("low_addr", 64'(lo_addr), 64'(e.hw));
                check("high_addr", 64'(hi_addr), 64'(e.hw + 18'd1));
                check("low_window", 64'(lo_cnt), 64'(A_MAIN));
                check("high_window", 64'(hi_cnt), 64'(A_MAIN));
                check("op_write", 64'(saw_wr), 64'(!e.is_rd));
                check("op_read", 64'(saw_rd), 64'(e.is_rd));
                if (!e.is_rd) begin
                    check("low_wdata", 64'(lo_data), 64'(e.wd[15:0]));
                    check("high_wdata", 64'(hi_data), 64'(e.wd[31:16]));
                end
                check("done_strobes", 64'({sram_we_n, sram_oe_n, sram_dq_oe}), 64'(3'b110));
                done_cnt++;
            end
            stall = 0; lo_cnt = 0; hi_cnt = 0; saw_wr = 1'b0; saw_rd = 1'b0;
        end
    end

    // Issue one request; returns in the DONE cycle (just after the edge).
    task automatic issue(input logic w, input logic r, input logic [31:0] a,
                         input logic [31:0] d, input bit pulse, input bit keep);
        exp_t e;
        int   idx;
        int   n;
        idx = int'(((a - 32'd1024) >> 2) % 32'd131072);
        e.is_rd = !w;
        e.wd    = d;
        e.hw    = 18'(idx * 2);
        if (w) ref_mem[idx] = d;
        else   last_read = ref_word(idx);
        e.exp_rd = last_read;
        sb_q.push_back(e);
        issued++;
        rd_en = r; wr_en = w; address = a; write_data = d;
        @(posedge clk); #1;
        if (pulse) begin
            rd_en = 1'b0; wr_en = 1'b0; address = $urandom; write_data = $urandom;
        end
        n = 0;
        while (ready !== 1'b1 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 60) begin
            checks++; failures++;
            $display("FAIL txn_timeout: got %0d cycles required below 60", n);
        end
        if (!keep) begin
            rd_en = 1'b0; wr_en = 1'b0; address = $urandom; write_data = $urandom;
        end
    endtask

    // Runs the same request on both aux instances and counts window lengths.
    task automatic aux_run(input bit w, input logic [31:0] d);
        int r1, r15, s1, s15, g1, g15;
        r1 = 0; r15 = 0; s1 = 0; s15 = 0; g1 = 0; g15 = 0;
        aux_wr = w; aux_rd = !w; aux_addr = 32'd1024; aux_wd = d;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (!a1_ready) r1++;
            if (!a15_ready) r15++;
            if (w ? !a1_we_n : !a1_oe_n) begin
                s1++;
                if ((a1_dq_oe == w) && (!w || a1_dq_out == (a1_addr == 18'd0 ? d[15:0] : d[31:16]))
                    && a1_addr <= 18'd1) g1++;
            end
            if (w ? !a15_we_n : !a15_oe_n) begin
                s15++;
                if ((a15_dq_oe == w) && (!w || a15_dq_out == (a15_addr == 18'd0 ? d[15:0] : d[31:16]))
                    && a15_addr <= 18'd1) g15++;
            end
            @(posedge clk); #1;
            aux_wr = 1'b0; aux_rd = 1'b0;
        end
        check("a1_ready_low", 64'(r1), 64'(3));
        check("a15_ready_low", 64'(r15), 64'(31));
        check("a1_strobe_window", 64'(s1), 64'(2));
        check("a15_strobe_window", 64'(s15), 64'(30));
        check("a1_window_content", 64'(g1), 64'(2));
        check("a15_window_content", 64'(g15), 64'(30));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, d;
        int          op, word;
        bit          keep, prev_keep, pulse;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_read_data", 64'(read_data), 64'(0));
        check("reset_ready", 64'(ready), 64'(1));
        check("reset_strobes", 64'({sram_we_n, sram_oe_n, sram_dq_oe}), 64'(3'b110));
        check("reset_addr", 64'(sram_addr), 64'(0));
        check("tied_enables", 64'({sram_ce_n, sram_ub_n, sram_lb_n, a1_ce_n, a1_ub_n,
                                   a1_lb_n, a15_ce_n, a15_ub_n, a15_lb_n}), 64'(0));

        // Store then load at halfwords 4/5.
        issue(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("sram_hw4", 64'(sram_mem[4]), 64'(16'hBEEF));
        check("sram_hw5", 64'(sram_mem[5]), 64'(16'hDEAD));
        issue(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;

        // Back-to-back: request held through DONE, address changed in DONE.
        issue(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0, 1'b1);
        issue(1'b0, 1'b1, 32'd1036, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;

        // One-cycle request pulse and the rd+wr combination.
        issue(1'b0, 1'b1, 32'd1024 + 32'd200, 32'h0, 1'b1, 1'b0);
        issue(1'b1, 1'b1, 32'd1024 + 32'd204, 32'h0BAD_F00D, 1'b0, 1'b0);
        @(posedge clk); #1;

        // Wrap and alignment: lands on halfwords 0/1.
        issue(1'b1, 1'b0, 32'd1024 + 32'h80003, 32'h1234_5678, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;

        prev_keep = 1'b0;
        for (int t = 0; t < 40; t++) begin
            op    = $urandom_range(0, 2);
            word  = $urandom_range(16, 255);
            a     = 32'd1024 + 32'(word * 4) + 32'($urandom_range(0, 3))
                    + (32'($urandom_range(0, 3)) << 21);
            d     = $urandom;
            keep  = ($urandom_range(0, 9) < 3);
            pulse = !prev_keep && ($urandom_range(0, 3) == 0);
            issue(op != 0, op != 1, a, d, pulse, keep);
            if (!keep) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            prev_keep = keep;
        end

        // Reset in the middle of the HIGH window of a write.
        rd_en = 1'b0; wr_en = 1'b1; address = 32'd1024 + 32'd4000; write_data = 32'hCAFE_0001;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0; wr_en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_read = '0;
        check("midreset_ready", 64'(ready), 64'(1));
        check("midreset_strobes", 64'({sram_we_n, sram_oe_n, sram_dq_oe}), 64'(3'b110));
        check("midreset_read_data", 64'(read_data), 64'(0));
        @(posedge clk); #1;
        issue(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;

        aux_run(1'b1, 32'hA1B2_C3D4);
        aux_run(1'b0, 32'h0);
        check("a1_read_data", 64'(a1_rdata), 64'({AUX_DQ, AUX_DQ}));
        check("a15_read_data", 64'(a15_rdata), 64'({AUX_DQ, AUX_DQ}));

        repeat (5) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb_q.size()), 64'(0));
        check("done_count", 64'(done_cnt), 64'(issued));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
